ysyx_22050058_imem_responder: RTL

//   Responder (memory side) of the instruction-fetch interface driven by the pipeline.

---
 rtl/ysyx_22050058_imem_responder.sv | 117 +++++++++++
 1 files changed

// File: rtl/ysyx_22050058_imem_responder.sv
// ysyx_22050058_imem_responder
//   Memory-side responder for the instruction-fetch interface. Accepts one
//   fetch request at a time (valid/ready), returns the addressed 32-bit word
//   after LATENCY cycles and holds the response until the pipeline takes it.
//   A side load port writes the instruction array at any time.
//
// Ports
//   clk          clock, all state on the rising edge
//   rst          synchronous active-high reset (array contents are kept)
//   req_valid_i  fetch request valid
//   req_ready_o  responder is idle and can accept a request
//   req_addr_i   byte address of the instruction to fetch
//   rsp_valid_o  response valid
//   rsp_ready_i  pipeline accepts the response
//   rsp_inst_o   fetched instruction (0 on error)
//   rsp_err_o    misaligned or out-of-range access
//   ld_en_i      load-port write enable
//   ld_idx_i     load-port word index
//   ld_data_i    load-port write data
module ysyx_22050058_imem_responder #(
  parameter int          ADDR_W     = 64,
  parameter int          INST_W     = 32,
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
  parameter int          LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_W-1:0]     req_addr_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [INST_W-1:0]     rsp_inst_o,
  output logic                  rsp_err_o,
  input  logic                  ld_en_i,
  input  logic [DEPTH_LOG2-1:0] ld_idx_i,
  input  logic [INST_W-1:0]     ld_data_i
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic [INST_W-1:0]   mem [DEPTH];
  logic [INST_W-1:0]   inst_cap;
  logic                err_cap;

  logic [ADDR_W-1:0]     off;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  err;

  // Misaligned, or offset beyond the array. The offset is an unsigned
  // subtraction, so addresses below the base wrap to huge values and fail.
  function automatic logic addr_err(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] ofs);
    return (addr[1:0] != 2'b00) || ((ofs >> (DEPTH_LOG2 + 2)) != '0);
  endfunction

  assign off = req_addr_i - BASE_ADDR[ADDR_W-1:0];
  assign idx = off[DEPTH_LOG2+1:2];
  assign err = addr_err(req_addr_i, off);

  // Load port: ungated by reset or state. A same-edge accept reads mem
  // before this write lands, giving read-before-write ordering.
  always_ff @(posedge clk) begin
    if (ld_en_i) mem[ld_idx_i] <= ld_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_inst_o  <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            // Capture the word now; later loads must not alter this response.
            inst_cap    <= err ? '0 : mem[idx];
            err_cap     <= err;
            cnt         <= CNT_INIT;
            req_ready_o <= 1'b0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          // Counter runs LATENCY-1 .. 0, so rsp_valid_o rises LATENCY edges
          // after the accept edge.
          if (cnt == 4'd0) begin
            rsp_inst_o  <= inst_cap;
            rsp_err_o   <= err_cap;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
